// File: rtl/stack_controller.sv
// Stack sequencer for the 256x8 data memory: PUSH/POP/CALL/RET, downward-growing stack, SP = next free slot.
// Latency: push/call 2 cycles, pop/ret 3 cycles, rejected op 2 cycles; op_ready low while busy, op_valid ignored then.
module stack_controller #(
    parameter logic [7:0] SP_RESET = 8'hFF,
    parameter logic [7:0] SP_LIMIT = 8'h80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    input  logic [1:0] op_code,
    input  logic [7:0] rn_in,
    input  logic [7:0] npc_in,
    output logic       op_ready,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_wr,
    input  logic [7:0] mem_rdata,
    output logic       pop_valid,
    output logic [7:0] pop_data,
    output logic       pc_load,
    output logic [7:0] pc_value,
    output logic       op_done,
    output logic [7:0] sp,
    output logic [8:0] depth,
    output logic       overflow,
    output logic       underflow,
    input  logic       err_clr
);

    localparam logic [8:0] CAPACITY = {1'b0, SP_RESET} - {1'b0, SP_LIMIT} + 9'd1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RESP,
        REJECT
    } state_t;

    state_t     state_q;
    logic [1:0] op_q;
    logic [7:0] sp_q;
    logic [8:0] depth_q;
    logic [7:0] wdata_q;
    logic [7:0] pop_data_q;
    logic [7:0] pc_value_q;
    logic       overflow_q;
    logic       underflow_q;

    logic       full_d;
    logic       empty_d;
    logic [7:0] sp_inc_d;

    assign full_d   = (depth_q == CAPACITY);
    assign empty_d  = (depth_q == 9'd0);
    assign sp_inc_d = sp_q + 8'd1;

    // op_code[0] selects read-type (POP/RET); op_code[1] selects the PC flavour (CALL/RET).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            sp_q        <= SP_RESET;
            depth_q     <= 9'd0;
            wdata_q     <= 8'h00;
            pop_data_q  <= 8'h00;
            pc_value_q  <= 8'h00;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (err_clr) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        op_q <= op_code;
                        if (!op_code[0]) begin
                            wdata_q <= op_code[1] ? npc_in : rn_in;
                            if (full_d) begin
                                overflow_q <= 1'b1;
                                state_q    <= REJECT;
                            end else begin
                                state_q    <= WRITE;
                            end
                        end else begin
                            if (empty_d) begin
                                underflow_q <= 1'b1;
                                state_q     <= REJECT;
                            end else begin
                                state_q     <= READ;
                            end
                        end
                    end
                end
                WRITE: begin
                    sp_q    <= sp_q - 8'd1;
                    depth_q <= depth_q + 9'd1;
                    state_q <= IDLE;
                end
                READ: begin
                    if (op_q[1]) begin
                        pc_value_q <= mem_rdata;
                    end else begin
                        pop_data_q <= mem_rdata;
                    end
                    sp_q    <= sp_inc_d;
                    depth_q <= depth_q - 9'd1;
                    state_q <= RESP;
                end
                RESP:    state_q <= IDLE;
                REJECT:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes are masked by rst_n so an op caught by reset never completes.
    assign op_ready  = (state_q == IDLE);
    assign mem_addr  = (state_q == READ) ? sp_inc_d : sp_q;
    assign mem_wdata = wdata_q;
    assign mem_wr    = (state_q == WRITE) && rst_n;
    assign op_done   = ((state_q == WRITE) || (state_q == RESP) || (state_q == REJECT)) && rst_n;
    assign pop_valid = (state_q == RESP) && !op_q[1] && rst_n;
    assign pc_load   = (state_q == RESP) && op_q[1] && rst_n;
    assign pop_data  = pop_data_q;
    assign pc_value  = pc_value_q;
    assign sp        = sp_q;
    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_controller.sv
// Scoreboard bench for stack_controller with a behavioural 256x8 memory.
module tb_stack_controller;

    logic       clk;
    logic       rst_n;
    logic       op_valid;
    logic [1:0] op_code;
    logic [7:0] rn_in;
    logic [7:0] npc_in;
    logic       op_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_wr;
    logic [7:0] mem_rdata;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic       pc_load;
    logic [7:0] pc_value;
    logic       op_done;
    logic [7:0] sp;
    logic [8:0] depth;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [1:0] kind;  // {pc_load, pop_valid}
        logic [7:0] data;
    } rsp_t;

    wr_t  wr_q[$];
    rsp_t rsp_q[$];
    int   checks;
    int   errors;
    int   exp_done;
    int   obs_done;

    logic [7:0] mem [256];

    stack_controller #(.SP_RESET(8'hFF), .SP_LIMIT(8'h80)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
        .rn_in(rn_in), .npc_in(npc_in), .op_ready(op_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .pop_valid(pop_valid), .pop_data(pop_data),
        .pc_load(pc_load), .pc_value(pc_value), .op_done(op_done),
        .sp(sp), .depth(depth), .overflow(overflow), .underflow(underflow),
        .err_clr(err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write / response the DUT presents must match the head of its queue.
    initial begin
        wr_t  w;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (mem_wr === 1'b1) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=addr %0h data %0h required=no write", mem_addr, mem_wdata);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", mem_addr, w.addr);
                    chk("wr_data", mem_wdata, w.data);
                    chk("wr_done", op_done, 1);
                end
            end
            if (pop_valid === 1'b1 || pc_load === 1'b1) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=%b required=no response", {pc_load, pop_valid});
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_kind", {pc_load, pop_valid}, r.kind);
                    chk("rsp_data", pc_load ? pc_value : pop_data, r.data);
                    chk("rsp_done", op_done, 1);
                end
            end
            if (op_done === 1'b1) obs_done++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic void exp_write(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wr_q.push_back(w);
        exp_done++;
    endfunction

    function automatic void exp_rsp(input logic [1:0] k, input logic [7:0] d);
        rsp_t r;
        r.kind = k;
        r.data = d;
        rsp_q.push_back(r);
        exp_done++;
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        op_valid = 1'b0;
        err_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called 1 time unit after a rising edge. gap = cycles from accept edge to next op_ready.
    task automatic issue(input logic [1:0] code, input logic [7:0] d, input logic clr,
                         output int gap, output logic [7:0] addr1);
        int n;
        n = 0;
        while (op_ready !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        if (op_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_wait actual=%b required=1", op_ready);
        end
        op_valid = 1'b1;
        op_code  = code;
        rn_in    = code[1] ? ~d : d;
        npc_in   = code[1] ? d : ~d;
        err_clr  = clr;
        @(posedge clk);
        #1 op_valid = 1'b0;
        err_clr = 1'b0;
        addr1   = mem_addr;
        gap     = 1;
        while (op_ready !== 1'b1 && gap < 10) begin
            @(posedge clk);
            #1 gap++;
        end
    endtask

    initial begin
        int         gap;
        logic [7:0] a1;
        logic [7:0] pv [3];
        checks   = 0;
        errors   = 0;
        exp_done = 0;
        obs_done = 0;
        op_code  = 2'b00;
        rn_in    = 8'h00;
        npc_in   = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'hC3;

        // Reset state
        do_reset();
        chk("rst_sp", sp, 8'hFF);
        chk("rst_depth", depth, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        chk("rst_pop_data", pop_data, 0);
        chk("rst_pc_value", pc_value, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ready", op_ready, 1);
        chk("rst_addr", mem_addr, 8'hFF);

        // Single PUSH
        exp_write(8'hFF, 8'hA5);
        issue(OP_PUSH, 8'hA5, 1'b0, gap, a1);
        chk("push_gap", gap, 2);
        chk("push_sp", sp, 8'hFE);
        chk("push_depth", depth, 1);
        chk("push_idle_addr", mem_addr, 8'hFE);

        // CALL then RET
        do_reset();
        exp_write(8'hFF, 8'h3C);
        issue(OP_CALL, 8'h3C, 1'b0, gap, a1);
        chk("call_gap", gap, 2);
        exp_rsp(2'b10, 8'h3C);
        issue(OP_RET, 8'h00, 1'b0, gap, a1);
        chk("ret_read_addr", a1, 8'hFF);
        chk("ret_gap", gap, 3);
        chk("ret_sp", sp, 8'hFF);
        chk("ret_depth", depth, 0);
        repeat (2) @(posedge clk);
        #1 chk("pc_value_hold", pc_value, 8'h3C);

        // LIFO ordering
        do_reset();
        pv[0] = 8'h11;
        pv[1] = 8'h22;
        pv[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            exp_write(8'hFF - 8'(i), pv[i]);
            issue(OP_PUSH, pv[i], 1'b0, gap, a1);
            chk("lifo_push_gap", gap, 2);
        end
        for (int i = 2; i >= 0; i--) begin
            exp_rsp(2'b01, pv[i]);
            issue(OP_POP, 8'h00, 1'b0, gap, a1);
            chk("lifo_pop_gap", gap, 3);
            chk("lifo_read_addr", a1, 8'hFF - 8'(i));
        end
        chk("lifo_sp", sp, 8'hFF);
        chk("lifo_pop_hold", pop_data, 8'h11);

        // Fill to capacity, then overflow
        do_reset();
        for (int i = 0; i < 128; i++) begin
            exp_write(8'hFF - 8'(i), 8'(i));
            issue(OP_PUSH, 8'(i), 1'b0, gap, a1);
        end
        chk("full_sp", sp, 8'h7F);
        chk("full_depth", depth, 128);
        chk("full_ovf_clear", overflow, 0);
        exp_done++;
        issue(OP_PUSH, 8'hEE, 1'b0, gap, a1);
        chk("ovf_gap", gap, 2);
        chk("ovf_flag", overflow, 1);
        chk("ovf_sp", sp, 8'h7F);
        chk("ovf_depth", depth, 128);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);
        exp_rsp(2'b01, 8'h7F);
        issue(OP_POP, 8'h00, 1'b0, gap, a1);
        chk("full_pop_addr", a1, 8'h80);
        chk("full_pop_depth", depth, 127);

        // Underflow, sticky, set beats clear
        do_reset();
        exp_done++;
        issue(OP_POP, 8'h00, 1'b0, gap, a1);
        chk("udf_gap", gap, 2);
        chk("udf_flag", underflow, 1);
        chk("udf_sp", sp, 8'hFF);
        chk("udf_depth", depth, 0);
        exp_done++;
        issue(OP_RET, 8'h00, 1'b1, gap, a1);
        chk("udf_set_wins", underflow, 1);
        chk("udf_pc_hold", pc_value, 0);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        chk("udf_cleared", underflow, 0);

        // Reset during WRITE discards the op
        do_reset();
        op_valid = 1'b1;
        op_code  = OP_PUSH;
        rn_in    = 8'h5A;
        @(posedge clk);
        #1 op_valid = 1'b0;
        chk("mid_in_write", op_ready, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_mem_wr", mem_wr, 0);
        chk("mid_op_done", op_done, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("mid_sp", sp, 8'hFF);
        chk("mid_depth", depth, 0);
        chk("mid_ready", op_ready, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("wr_queue_empty", wr_q.size(), 0);
        chk("rsp_queue_empty", rsp_q.size(), 0);
        chk("op_done_count", obs_done, exp_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_controller.md
Name: stack_controller

Overview:
- Initiator-side sequencer that drives the 256x8 data memory for stack traffic: PUSH, POP, CALL, RET.
- Owns the stack pointer and generates address, write data and write strobe toward the memory.
- Returns popped data to the register file, or the return address to the PC.
- Stack grows downward. SP points at the next free location.

Parameters:
- SP_RESET, 8'hFF: SP value after reset. This is the top of the stack region.
- SP_LIMIT, 8'h80: lowest usable stack address. Stack capacity is SP_RESET-SP_LIMIT+1 entries.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- op_valid  in  1  operation request
- op_code  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET
- rn_in  in  8  register value to push (PUSH)
- npc_in  in  8  next-PC value to push (CALL)
- op_ready  out  1  controller idle and able to accept an op
- mem_addr  out  8  data memory address
- mem_wdata  out  8  data memory write data
- mem_wr  out  1  data memory write strobe; memory writes on the rising edge
- mem_rdata  in  8  data memory read data; combinational from mem_addr
- pop_valid  out  1  one-cycle pulse: pop_data valid (POP)
- pop_data  out  8  popped value
- pc_load  out  1  one-cycle pulse: pc_value valid (RET)
- pc_value  out  8  return address
- op_done  out  1  one-cycle pulse at completion of every accepted op, including rejected ones
- sp  out  8  current stack pointer
- depth  out  9  current number of entries
- overflow  out  1  sticky: a PUSH or CALL was attempted while full
- underflow  out  1  sticky: a POP or RET was attempted while empty
- err_clr  in  1  clears overflow and underflow

Behaviour:
- Reset values (rst_n low at an edge):
  - State IDLE; sp=SP_RESET; depth=0.
  - overflow=0, underflow=0; all pulses 0.
  - pop_data=0, pc_value=0, mem_wdata=0.
- Gating during reset: mem_wr = (state==WRITE) AND rst_n, so no write can occur in a reset cycle.
- States: IDLE, WRITE, READ, RESP, REJECT.
- IDLE:
  - op_ready=1, mem_addr=sp, mem_wr=0.
  - On op_valid=1 at an edge, the op is accepted.
  - op_code, and the data (rn_in for PUSH, npc_in for CALL), are captured into mem_wdata.
- Transitions out of IDLE on acceptance:
  - PUSH/CALL with depth < capacity -> WRITE.
  - POP/RET with depth > 0 -> READ.
  - PUSH/CALL while full -> set overflow, go to REJECT.
  - POP/RET while empty -> set underflow, go to REJECT.
- WRITE (1 cycle):
  - mem_addr=sp, mem_wr=1, op_done=1.
  - At the edge: sp<=sp-1, depth<=depth+1, then IDLE.
- READ (1 cycle):
  - mem_addr=sp+1 (8-bit), mem_wr=0.
  - At the edge: mem_rdata is captured into pop_data (POP) or pc_value (RET); sp<=sp+1, depth<=depth-1; then RESP.
- RESP (1 cycle):
  - op_done=1; pop_valid=1 (POP) or pc_load=1 (RET). Then IDLE.
- REJECT (1 cycle):
  - op_done=1. No memory access, sp and depth unchanged. Then IDLE.
- Latency and throughput:
  - PUSH/CALL: 2 cycles, accept to next op_ready.
  - POP/RET: 3 cycles.
  - Rejected op: 2 cycles.
  - op_ready=0 in every non-IDLE state; op_valid is ignored there.
- Outside the active cycles, pop_data and pc_value hold their last value.
- Arithmetic: sp is 8-bit modulo 256. With legal parameters (SP_LIMIT<=SP_RESET), full/empty checks prevent any wrap.
- Flags:
  - overflow and underflow stay set until err_clr=1 or reset.
  - If err_clr and a new error occur in the same edge, set wins.
- Reset mid-op: any state returns to IDLE and the op is discarded. No mem_wr, pop_valid, pc_load or op_done is issued for it.

Test Plan:
- Reset, then PUSH rn_in=8'hA5 -> WRITE cycle shows mem_addr=8'hFF, mem_wdata=8'hA5, mem_wr=1, op_done=1; afterwards sp=8'hFE, depth=1.
- CALL npc_in=8'h3C, then RET -> READ cycle shows mem_addr=8'hFF; RESP cycle shows pc_load=1, pc_value=8'h3C; sp returns to 8'hFF, depth=0.
- PUSH 8'h11, 8'h22, 8'h33, then three POPs -> pop_data sequence 8'h33, 8'h22, 8'h11, each with a single pop_valid pulse; op_ready gaps are 2 cycles per push and 3 per pop.
- Fill 128 entries (SP_LIMIT=8'h80), then PUSH -> overflow=1, mem_wr never asserted, sp=8'h7F, depth=128. Then err_clr=1 -> overflow=0.
- POP on empty after reset -> underflow=1, op_done pulse, no pop_valid, sp=8'hFF. A further RET keeps underflow=1.
- Accept PUSH, drive rst_n=0 during the WRITE cycle -> mem_wr=0 in that cycle, sp=8'hFF, depth=0, op_ready=1 after release.
